// File: rtl/softmax_pkg.sv
// Shared constants and types for the consmax output collector.
package softmax_pkg;

    localparam int GBUS_DATA  = 64;
    localparam int GBUS_WIDTH = GBUS_DATA / 8;
    localparam int NUM_HEAD   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int HEAD_IDX_W = $clog2(NUM_HEAD);

    typedef logic [GBUS_WIDTH-1:0] lane_mask_t;
    typedef logic [GBUS_DATA-1:0]  head_word_t;

endpackage

// File: rtl/consmax_odata_collector_if.sv
// Strobed per-head input bus and valid/ready result bus of the collector.
interface consmax_odata_collector_if #(
    parameter int GBUS_DATA  = softmax_pkg::GBUS_DATA,
    parameter int GBUS_WIDTH = softmax_pkg::GBUS_WIDTH,
    parameter int NUM_HEAD   = softmax_pkg::NUM_HEAD
);
    logic [GBUS_DATA*NUM_HEAD-1:0]  odata;
    logic [GBUS_WIDTH*NUM_HEAD-1:0] odata_valid;
    logic [NUM_HEAD-1:0]            in_ready;
    logic [GBUS_DATA-1:0]           out_data;
    logic [$clog2(NUM_HEAD)-1:0]    out_head;
    logic                           out_valid;
    logic                           out_ready;

    modport master (
        output odata, odata_valid, out_ready,
        input  in_ready, out_data, out_head, out_valid
    );

    modport slave (
        input  odata, odata_valid, out_ready,
        output in_ready, out_data, out_head, out_valid
    );
endinterface

// File: rtl/consmax_odata_collector_fifo.sv
// Per-head synchronous word FIFO with registered occupancy count.
module collect_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/consmax_odata_collector.sv
// Merges byte-strobed per-head odata into words, buffers per head, drains round-robin.
// Optional COLLECT_FLUSH_EN adds a flush input that pushes partial words zero-filled.
module consmax_odata_collector #(
    parameter int GBUS_DATA  = softmax_pkg::GBUS_DATA,
    parameter int GBUS_WIDTH = softmax_pkg::GBUS_WIDTH,
    parameter int NUM_HEAD   = softmax_pkg::NUM_HEAD,
    parameter int FIFO_DEPTH = softmax_pkg::FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
`ifdef COLLECT_FLUSH_EN
    input  logic flush,
`endif
    consmax_odata_collector_if.slave bus,
    output logic overflow_err,
    output logic dup_err
);
    localparam int HW = $clog2(NUM_HEAD);

    logic [GBUS_WIDTH-1:0] mask_q [NUM_HEAD];
    logic [GBUS_WIDTH-1:0] mask_d [NUM_HEAD];
    logic [GBUS_DATA-1:0]  asm_q  [NUM_HEAD];
    logic [GBUS_DATA-1:0]  asm_d  [NUM_HEAD];
    logic [GBUS_DATA-1:0]  push_word [NUM_HEAD];
    logic [GBUS_DATA-1:0]  pop_word  [NUM_HEAD];
    logic [NUM_HEAD-1:0]   push, pop, full, empty;
    logic                  ovf_q, ovf_d, dup_q, dup_d;
    logic                  vld_q, vld_d;
    logic [GBUS_DATA-1:0]  data_q, data_d;
    logic [HW-1:0]         head_q, head_d, rr_q, rr_d;

    function automatic logic [GBUS_DATA-1:0] lane_expand(input logic [GBUS_WIDTH-1:0] m);
        for (int b = 0; b < GBUS_WIDTH; b++) lane_expand[b*8 +: 8] = {8{m[b]}};
    endfunction

    // Assembly: merge accepted strobes, push when complete (or flushed)
    always_comb begin
        logic [GBUS_WIDTH-1:0] strb;
        logic [GBUS_DATA-1:0]  lanes;
        strb  = '0;
        lanes = '0;
        ovf_d = ovf_q;
        dup_d = dup_q;
        for (int h = 0; h < NUM_HEAD; h++) begin
            strb         = bus.odata_valid[h*GBUS_WIDTH +: GBUS_WIDTH];
            lanes        = lane_expand(strb);
            mask_d[h]    = mask_q[h];
            asm_d[h]     = asm_q[h];
            push[h]      = 1'b0;
            push_word[h] = asm_q[h];
            if (|strb) begin
                if (full[h]) begin
                    ovf_d = 1'b1;
                end else begin
                    if (|(mask_q[h] & strb)) dup_d = 1'b1;
                    asm_d[h]  = (asm_q[h] & ~lanes) | (bus.odata[h*GBUS_DATA +: GBUS_DATA] & lanes);
                    mask_d[h] = mask_q[h] | strb;
                end
            end
            if (!full[h] && (&mask_d[h])) begin
                push[h]      = 1'b1;
                push_word[h] = asm_d[h];
                mask_d[h]    = '0;
            end
`ifdef COLLECT_FLUSH_EN
            else if (flush && !full[h] && (|mask_d[h])) begin
                push[h]      = 1'b1;
                push_word[h] = asm_d[h] & lane_expand(mask_d[h]);
                mask_d[h]    = '0;
            end
`endif
        end
    end

    for (genvar h = 0; h < NUM_HEAD; h++) begin : g_fifo
        collect_fifo #(
            .W     (GBUS_DATA),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[h]),
            .push_data (push_word[h]),
            .pop       (pop[h]),
            .pop_data  (pop_word[h]),
            .full      (full[h]),
            .empty     (empty[h])
        );
    end

    // Round-robin grant from rr_q; the output register refills whenever it is free or draining
    always_comb begin
        logic          found;
        logic [HW-1:0] gnt;
        int            idx;
        found  = 1'b0;
        gnt    = '0;
        idx    = 0;
        pop    = '0;
        rr_d   = rr_q;
        vld_d  = vld_q;
        data_d = data_q;
        head_d = head_q;
        for (int i = 0; i < NUM_HEAD; i++) begin
            idx = (int'(rr_q) + i) % NUM_HEAD;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                gnt   = HW'(idx);
            end
        end
        if (!vld_q || bus.out_ready) begin
            vld_d = found;
            if (found) begin
                pop[gnt] = 1'b1;
                data_d   = pop_word[gnt];
                head_d   = gnt;
                rr_d     = (int'(gnt) == NUM_HEAD-1) ? '0 : gnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < NUM_HEAD; h++) mask_q[h] <= '0;
            ovf_q  <= 1'b0;
            dup_q  <= 1'b0;
            vld_q  <= 1'b0;
            data_q <= '0;
            head_q <= '0;
            rr_q   <= '0;
        end else begin
            for (int h = 0; h < NUM_HEAD; h++) mask_q[h] <= mask_d[h];
            ovf_q  <= ovf_d;
            dup_q  <= dup_d;
            vld_q  <= vld_d;
            data_q <= data_d;
            head_q <= head_d;
            rr_q   <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int h = 0; h < NUM_HEAD; h++) asm_q[h] <= asm_d[h];
    end

    assign bus.in_ready  = ~full;
    assign bus.out_valid = vld_q;
    assign bus.out_data  = data_q;
    assign bus.out_head  = head_q;
    assign overflow_err  = ovf_q;
    assign dup_err       = dup_q;
endmodule

// File: tb/tb_consmax_odata_collector.sv
// Directed bench for consmax_odata_collector; flush case included when COLLECT_FLUSH_EN is defined.
module tb_consmax_odata_collector;
    import softmax_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic ovf, dup;
`ifdef COLLECT_FLUSH_EN
    logic flush;
`endif
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    consmax_odata_collector_if bus ();

    consmax_odata_collector dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef COLLECT_FLUSH_EN
        .flush        (flush),
`endif
        .bus          (bus),
        .overflow_err (ovf),
        .dup_err      (dup)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input int h, input head_word_t word, input lane_mask_t strb);
        bus.odata[h*GBUS_DATA +: GBUS_DATA]         = word;
        bus.odata_valid[h*GBUS_WIDTH +: GBUS_WIDTH] = strb;
    endtask

    task automatic clear_strb();
        bus.odata_valid = '0;
    endtask

    head_word_t w3 [5];
    int         seen;

    initial begin
        rst_n           = 1'b0;
        bus.odata       = '0;
        bus.odata_valid = '0;
        bus.out_ready   = 1'b1;
`ifdef COLLECT_FLUSH_EN
        flush = 1'b0;
`endif
        for (int k = 0; k < 5; k++) w3[k] = 64'hC0DE_0000_0000_0000 + 64'(k);
        tick();
        tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_out_head", 64'(bus.out_head), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'hFF);
        check("rst_errs", {62'd0, ovf, dup}, 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: two half strobes build one word on head 0
        set_head(0, 64'h0807060504030201, 8'h0F);
        tick();
        set_head(0, 64'h0807060504030201, 8'hF0);
        tick();
        clear_strb();
        check("t1_not_yet", 64'(bus.out_valid), 64'd0);
        tick();
        check("t1_valid", 64'(bus.out_valid), 64'd1);
        check("t1_data", bus.out_data, 64'h0807060504030201);
        check("t1_head", 64'(bus.out_head), 64'd0);
        tick();
        check("t1_single_beat", 64'(bus.out_valid), 64'd0);

        // 2: simultaneous completions drain in round-robin order
        set_head(2, 64'h2222_2222_2222_2222, 8'hFF);
        set_head(5, 64'h5555_5555_5555_5555, 8'hFF);
        set_head(7, 64'h7777_7777_7777_7777, 8'hFF);
        tick();
        clear_strb();
        tick();
        check("t2_head_a", 64'(bus.out_head), 64'd2);
        check("t2_data_a", bus.out_data, 64'h2222_2222_2222_2222);
        tick();
        check("t2_head_b", 64'(bus.out_head), 64'd5);
        tick();
        check("t2_head_c", 64'(bus.out_head), 64'd7);
        check("t2_data_c", bus.out_data, 64'h7777_7777_7777_7777);
        tick();
        check("t2_idle", 64'(bus.out_valid), 64'd0);
        set_head(7, 64'h7070_7070_7070_7070, 8'hFF);
        set_head(0, 64'h0A0A_0A0A_0A0A_0A0A, 8'hFF);
        tick();
        clear_strb();
        tick();
        check("t2_wrap_head0", 64'(bus.out_head), 64'd0);
        tick();
        check("t2_wrap_head7", 64'(bus.out_head), 64'd7);
        tick();

        // 3: backpressure fills head 1 FIFO, fifth word dropped
        bus.out_ready = 1'b0;
        set_head(6, 64'h6666_6666_6666_6666, 8'hFF);
        tick();
        clear_strb();
        tick();
        check("t3_hold_valid", 64'(bus.out_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            set_head(1, w3[k], 8'hFF);
            tick();
            if (k == 2) check("t3_ready_at3", 64'(bus.in_ready[1]), 64'd1);
            if (k == 3) begin
                check("t3_full", 64'(bus.in_ready[1]), 64'd0);
                check("t3_no_ovf_yet", 64'(ovf), 64'd0);
            end
        end
        clear_strb();
        check("t3_overflow", 64'(ovf), 64'd1);
        check("t3_stable_head", 64'(bus.out_head), 64'd6);
        check("t3_stable_data", bus.out_data, 64'h6666_6666_6666_6666);
        bus.out_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_word%0d", k), bus.out_data, w3[k]);
            check($sformatf("t3_head%0d", k), {63'd0, bus.out_valid} << 8 | 64'(bus.out_head), 64'h101);
            tick();
        end
        check("t3_drained", 64'(bus.out_valid), 64'd0);
        check("t3_ready_back", 64'(bus.in_ready[1]), 64'd1);
        check("t3_no_dup", 64'(dup), 64'd0);

        // 4: duplicate lane strobe overwrites, no push
        set_head(3, 64'h11, 8'h01);
        tick();
        set_head(3, 64'h22, 8'h01);
        tick();
        clear_strb();
        check("t4_dup", 64'(dup), 64'd1);
        tick();
        check("t4_no_push_a", 64'(bus.out_valid), 64'd0);
        tick();
        check("t4_no_push_b", 64'(bus.out_valid), 64'd0);
        set_head(3, 64'h9988776655443300, 8'hFE);
        tick();
        clear_strb();
        tick();
        check("t4_valid", 64'(bus.out_valid), 64'd1);
        check("t4_data", bus.out_data, 64'h9988776655443322);
        check("t4_head", 64'(bus.out_head), 64'd3);
        tick();

`ifdef COLLECT_FLUSH_EN
        // 5: flush pushes a partial word zero-filled
        set_head(4, 64'h112233445566BBAA, 8'h03);
        tick();
        clear_strb();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("t5_valid", 64'(bus.out_valid), 64'd1);
        check("t5_data", bus.out_data, 64'h000000000000BBAA);
        check("t5_head", 64'(bus.out_head), 64'd4);
        tick();
`endif

        // 6: asynchronous reset with words buffered and a partial on head 5
        bus.out_ready = 1'b0;
        set_head(0, 64'hA0, 8'hFF);
        set_head(1, 64'hA1, 8'hFF);
        set_head(2, 64'hA2, 8'hFF);
        set_head(3, 64'hA3, 8'hFF);
        set_head(5, 64'hA5, 8'h0F);
        tick();
        clear_strb();
        tick();
        check("t6_pre_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 64'(bus.out_valid), 64'd0);
        check("t6_async_data", bus.out_data, 64'd0);
        check("t6_async_head", 64'(bus.out_head), 64'd0);
        check("t6_async_ready", 64'(bus.in_ready), 64'hFF);
        check("t6_async_errs", {62'd0, ovf, dup}, 64'd0);
        tick();
        tick();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        set_head(5, 64'hB5B5B5B5_00000000, 8'hF0);
        tick();
        clear_strb();
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("t6_nothing_drains", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
